// File: rtl/mips_instr_encoder_if.sv
// Instruction-load bus between a program source and mips_instr_encoder:
// the symbolic instruction handshake plus the resulting IMEM write port.
interface mips_instr_encoder_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_mnem;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [15:0]       in_imm;
  logic [ADDR_W-1:0] in_target;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  // Program source: presents instructions, observes the IMEM write port.
  modport master (
    output in_valid, in_mnem, in_rs, in_rt, in_rd, in_imm, in_target,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  // Encoder: accepts instructions, drives the IMEM write port.
  modport slave (
    input  in_valid, in_mnem, in_rs, in_rt, in_rd, in_imm, in_target,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/mips_instr_encoder.sv
// Symbolic-to-binary MIPS instruction encoder that streams words into IMEM
// starting at address 0 of each load session.
// Optional feature: define DELAY_SLOT_NOP_EN to append a NOP after every
// BEQ/BNE/J (the FSM spends one cycle in a SLOT state writing it).
module mips_instr_encoder #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic                  clk_i,
  input  logic                  nrst_i,
  input  logic                  start_i,
  mips_instr_encoder_if.slave   bus,
  output logic [ADDR_W:0]       count_o,
  output logic                  full_o,
  output logic                  overflow_err_o
);

  localparam logic [ADDR_W:0] DepthC = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CntOne = (ADDR_W+1)'(1);

  // Mnemonic codes presented on in_mnem.
  localparam logic [3:0] MnAdd   = 4'd0;
  localparam logic [3:0] MnSub   = 4'd1;
  localparam logic [3:0] MnAnd   = 4'd2;
  localparam logic [3:0] MnOr    = 4'd3;
  localparam logic [3:0] MnSlt   = 4'd4;
  localparam logic [3:0] MnAddi  = 4'd5;
  localparam logic [3:0] MnAddiu = 4'd6;
  localparam logic [3:0] MnAndi  = 4'd7;
  localparam logic [3:0] MnOri   = 4'd8;
  localparam logic [3:0] MnSlti  = 4'd9;
  localparam logic [3:0] MnLui   = 4'd10;
  localparam logic [3:0] MnLw    = 4'd11;
  localparam logic [3:0] MnSw    = 4'd12;
  localparam logic [3:0] MnBeq   = 4'd13;
  localparam logic [3:0] MnBne   = 4'd14;
  localparam logic [3:0] MnJ     = 4'd15;

  // Opcodes and functs the core's control decodes.
  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAddiu = 6'h09;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpSlti  = 6'h0A;
  localparam logic [5:0] OpLui   = 6'h0F;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpJ     = 6'h02;

  localparam logic [5:0] FnAdd   = 6'h20;
  localparam logic [5:0] FnSub   = 6'h22;
  localparam logic [5:0] FnAnd   = 6'h24;
  localparam logic [5:0] FnOr    = 6'h25;
  localparam logic [5:0] FnSlt   = 6'h2A;

`ifdef DELAY_SLOT_NOP_EN
  typedef enum logic [1:0] {StIdle, StRun, StFull, StSlot} state_e;
`else
  typedef enum logic [1:0] {StIdle, StRun, StFull} state_e;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              in_ready_q, in_ready_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic [31:0]       enc_word;
  logic              enc_is_branch;
  logic [16:0]       br_off;
  logic              xfer;

  // Encode the presented instruction; the write address is the current count.
  always_comb begin
    enc_word      = '0;
    enc_is_branch = 1'b0;
    br_off        = 17'(bus.in_target) - 17'(count_q) - 17'd1;
    unique case (bus.in_mnem)
      MnAdd:   enc_word = {OpRtype, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, FnAdd};
      MnSub:   enc_word = {OpRtype, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, FnSub};
      MnAnd:   enc_word = {OpRtype, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, FnAnd};
      MnOr:    enc_word = {OpRtype, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, FnOr};
      MnSlt:   enc_word = {OpRtype, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, FnSlt};
      MnAddi:  enc_word = {OpAddi, bus.in_rs, bus.in_rt, bus.in_imm};
      MnAddiu: enc_word = {OpAddiu, bus.in_rs, bus.in_rt, bus.in_imm};
      MnAndi:  enc_word = {OpAndi, bus.in_rs, bus.in_rt, bus.in_imm};
      MnOri:   enc_word = {OpOri, bus.in_rs, bus.in_rt, bus.in_imm};
      MnSlti:  enc_word = {OpSlti, bus.in_rs, bus.in_rt, bus.in_imm};
      MnLui:   enc_word = {OpLui, 5'd0, bus.in_rt, bus.in_imm};
      MnLw:    enc_word = {OpLw, bus.in_rs, bus.in_rt, bus.in_imm};
      MnSw:    enc_word = {OpSw, bus.in_rs, bus.in_rt, bus.in_imm};
      MnBeq: begin
        enc_word      = {OpBeq, bus.in_rs, bus.in_rt, br_off[15:0]};
        enc_is_branch = 1'b1;
      end
      MnBne: begin
        enc_word      = {OpBne, bus.in_rs, bus.in_rt, br_off[15:0]};
        enc_is_branch = 1'b1;
      end
      MnJ: begin
        enc_word      = {OpJ, 26'(bus.in_target)};
        enc_is_branch = 1'b1;
      end
      default: enc_word = '0;
    endcase
  end

  assign xfer = bus.in_valid & in_ready_q;

  // Next-state, write-port and registered-ready logic; start overrides all.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (start_i) begin
      state_d = StRun;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: state_d = StIdle;
        StRun: begin
          if (xfer) begin
            we_d    = 1'b1;
            addr_d  = count_q[ADDR_W-1:0];
            wdata_d = enc_word;
            count_d = count_q + CntOne;
            if (count_d == DepthC) begin
              state_d = StFull;
`ifdef DELAY_SLOT_NOP_EN
            end else if (enc_is_branch) begin
              state_d = StSlot;
`endif
            end
          end
        end
        StFull: begin
          if (bus.in_valid) ovf_d = 1'b1;
        end
`ifdef DELAY_SLOT_NOP_EN
        StSlot: begin
          we_d    = 1'b1;
          addr_d  = count_q[ADDR_W-1:0];
          wdata_d = '0;
          count_d = count_q + CntOne;
          state_d = (count_d == DepthC) ? StFull : StRun;
        end
`endif
        default: state_d = StIdle;
      endcase
    end
    in_ready_d = (state_d == StRun) && (count_d != DepthC);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      state_q    <= StIdle;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      in_ready_q <= in_ready_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign count_o        = count_q;
  assign full_o         = (count_q == DepthC);
  assign overflow_err_o = ovf_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed bench for mips_instr_encoder (DEPTH=8 so the full boundary is reachable).
module tb_mips_instr_encoder;
  localparam int unsigned AW = 10;
  localparam int unsigned DP = 8;

  logic          clk = 1'b0;
  logic          nrst;
  logic          start;
  logic [AW:0]   count;
  logic          full;
  logic          ovf;
  int            n_vec = 0;
  int            n_err = 0;

  logic [3:0]    v_m   [8];
  logic [4:0]    v_rs  [8];
  logic [4:0]    v_rt  [8];
  logic [4:0]    v_rd  [8];
  logic [15:0]   v_imm [8];
  logic [9:0]    v_tgt [8];
  logic [31:0]   v_exp [8];

  always #5 clk = ~clk;

  mips_instr_encoder_if #(.ADDR_W(AW)) bus ();

  mips_instr_encoder #(.ADDR_W(AW), .DEPTH(DP)) dut (
    .clk_i          (clk),
    .nrst_i         (nrst),
    .start_i        (start),
    .bus            (bus),
    .count_o        (count),
    .full_o         (full),
    .overflow_err_o (ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic drive(input logic [3:0] m, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [15:0] imm, input logic [9:0] tgt);
    bus.in_mnem   = m;
    bus.in_rs     = rs;
    bus.in_rt     = rt;
    bus.in_rd     = rd;
    bus.in_imm    = imm;
    bus.in_target = tgt;
    bus.in_valid  = 1'b1;
  endtask

  task automatic chk_wr(input string tag, input logic [31:0] addr, input logic [31:0] word);
    chk({tag, "_we"}, 32'(bus.imem_we), 32'd1);
    chk({tag, "_addr"}, 32'(bus.imem_addr), addr);
    chk({tag, "_wdata"}, bus.imem_wdata, word);
  endtask

  initial begin
    v_m   = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd10, 4'd8, 4'd14};
    v_rs  = '{5'd4, 5'd7, 5'd31, 5'd1, 5'd2, 5'd5, 5'd1, 5'd3};
    v_rt  = '{5'd5, 5'd8, 5'd31, 5'd2, 5'd3, 5'd4, 5'd1, 5'd4};
    v_rd  = '{5'd6, 5'd9, 5'd31, 5'd3, 5'd9, 5'd9, 5'd9, 5'd9};
    v_imm = '{16'hFFFF, 16'h1234, 16'h0, 16'h0, 16'h8000, 16'hABCD, 16'h00FF, 16'h5555};
    v_tgt = '{10'h3, 10'h3, 10'h3, 10'h3, 10'h3, 10'h3, 10'h3, 10'h3FF};
    v_exp = '{32'h00853022, 32'h00E84824, 32'h03FFF825, 32'h0022182A,
              32'h24438000, 32'h3C04ABCD, 32'h342100FF, 32'h146403F7};

    nrst  = 1'b0;
    start = 1'b0;
    drive(4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 10'd0);
    bus.in_valid = 1'b0;
    tick();
    tick();
    chk("rst_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_we", 32'(bus.imem_we), 32'd0);
    chk("rst_addr", 32'(bus.imem_addr), 32'd0);
    chk("rst_wdata", bus.imem_wdata, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);

    // IDLE ignores in_valid.
    nrst = 1'b1;
    drive(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 10'd0);
    tick();
    chk("idle_we", 32'(bus.imem_we), 32'd0);
    chk("idle_count", 32'(count), 32'd0);
    chk("idle_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_ready", 32'(bus.in_ready), 32'd1);

    // Single ADD, then scramble inputs after the handshake.
    drive(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 10'd0);
    tick();
    drive(4'd1, 5'd9, 5'd9, 5'd9, 16'hFFFF, 10'h3FF);
    bus.in_valid = 1'b0;
    chk_wr("add", 32'd0, 32'h00221820);
    chk("add_count", 32'(count), 32'd1);
    tick();
    chk("add_idle_we", 32'(bus.imem_we), 32'd0);
    chk("add_hold_count", 32'(count), 32'd1);

    // New session: back-to-back ADDI, LW, SW, BEQ, J.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_count", 32'(count), 32'd0);
    drive(4'd5, 5'd0, 5'd1, 5'd0, 16'd5, 10'd0);
    tick();
    chk_wr("addi", 32'd0, 32'h20010005);
    drive(4'd11, 5'd1, 5'd2, 5'd0, 16'd4, 10'd0);
    tick();
    chk_wr("lw", 32'd1, 32'h8C220004);
    drive(4'd12, 5'd1, 5'd2, 5'd0, 16'd8, 10'd0);
    tick();
    chk_wr("sw", 32'd2, 32'hAC220008);
    chk("sw_count", 32'(count), 32'd3);
    drive(4'd13, 5'd1, 5'd2, 5'd7, 16'h1234, 10'd0);
    tick();
    chk_wr("beq", 32'd3, 32'h1022FFFC);
    chk("beq_count", 32'(count), 32'd4);
`ifdef DELAY_SLOT_NOP_EN
    chk("slot_ready", 32'(bus.in_ready), 32'd0);
    drive(4'd15, 5'd3, 5'd3, 5'd3, 16'hFFFF, 10'h10);
    tick();
    chk_wr("nop", 32'd4, 32'h00000000);
    chk("nop_count", 32'(count), 32'd5);
    chk("post_slot_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk_wr("j", 32'd5, 32'h08000010);
    chk("j_count", 32'(count), 32'd6);
`else
    chk("beq_ready", 32'(bus.in_ready), 32'd1);
    drive(4'd15, 5'd3, 5'd3, 5'd3, 16'hFFFF, 10'h10);
    tick();
    chk_wr("j", 32'd4, 32'h08000010);
    chk("j_count", 32'(count), 32'd5);
`endif
    bus.in_valid = 1'b0;
    tick();

    // Fill a fresh session to DEPTH; the last word is a BNE so no slot fits.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(v_m[i], v_rs[i], v_rt[i], v_rd[i], v_imm[i], v_tgt[i]);
      tick();
      chk_wr($sformatf("fill%0d", i), 32'(i), v_exp[i]);
    end
    chk("full_flag", 32'(full), 32'd1);
    chk("full_ready", 32'(bus.in_ready), 32'd0);
    chk("full_count", 32'(count), 32'd8);
    drive(4'd0, 5'd1, 5'd1, 5'd1, 16'd0, 10'd0);
    tick();
    chk("ovf_set", 32'(ovf), 32'd1);
    chk("ovf_no_we", 32'(bus.imem_we), 32'd0);
    chk("ovf_count", 32'(count), 32'd8);
    bus.in_valid = 1'b0;
    tick();
    chk("ovf_sticky", 32'(ovf), 32'd1);
    chk("ovf_addr_hold", 32'(bus.imem_addr), 32'd7);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("clr_ovf", 32'(ovf), 32'd0);
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_full", 32'(full), 32'd0);
    chk("clr_ready", 32'(bus.in_ready), 32'd1);

    drive(4'd7, 5'd2, 5'd3, 5'd0, 16'h0F0F, 10'd0);
    tick();
    chk_wr("andi", 32'd0, 32'h30430F0F);
    drive(4'd9, 5'd6, 5'd7, 5'd0, 16'hFFFE, 10'd0);
    tick();
    chk_wr("slti", 32'd1, 32'h28C7FFFE);
    drive(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 10'd0);
    tick();
    chk_wr("add2", 32'd2, 32'h00221820);

    // Reset mid-stream with in_valid held high.
    nrst = 1'b0;
    tick();
    chk("mrst_ready", 32'(bus.in_ready), 32'd0);
    chk("mrst_we", 32'(bus.imem_we), 32'd0);
    chk("mrst_addr", 32'(bus.imem_addr), 32'd0);
    chk("mrst_wdata", bus.imem_wdata, 32'd0);
    chk("mrst_count", 32'(count), 32'd0);
    chk("mrst_full", 32'(full), 32'd0);
    chk("mrst_ovf", 32'(ovf), 32'd0);
    nrst = 1'b1;
    tick();
    tick();
    chk("mrst_idle_we", 32'(bus.imem_we), 32'd0);
    chk("mrst_idle_count", 32'(count), 32'd0);

    // start with in_valid from IDLE, then from RUN with a nonzero count.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("sv_idle_we", 32'(bus.imem_we), 32'd0);
    chk("sv_idle_count", 32'(count), 32'd0);
    tick();
    chk_wr("sv_add", 32'd0, 32'h00221820);
    chk("sv_add_count", 32'(count), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    bus.in_valid = 1'b0;
    chk("sv_run_we", 32'(bus.imem_we), 32'd0);
    chk("sv_run_count", 32'(count), 32'd0);
    tick();
    chk("sv_run_we2", 32'(bus.imem_we), 32'd0);
    chk("sv_run_count2", 32'(count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mips_instr_encoder.md
Name: mips_instr_encoder

Overview:
- Encoder counterpart of the core's opcode decoder: accepts symbolic instructions over a valid/ready handshake, assembles 32-bit MIPS words and writes them sequentially into instruction memory.
- Used by the test and boot infrastructure to load programs into IMEM before releasing the core from reset.
- Emitted opcodes and functs are exactly the set the core's control decodes.

Parameters:
- ADDR_W, 10: IMEM word-address width.
- DEPTH, 1024: IMEM capacity in words. Must be ≤ 2^ADDR_W.

Ports:
- clk  in  1  clock, rising edge.
- nrst  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse: begin a new load session at address 0.
- in_valid  in  1  an instruction is presented.
- in_ready  out  1  encoder can accept this cycle.
- in_mnem  in  4  mnemonic code (see Behaviour).
- in_rs  in  5  rs field.
- in_rt  in  5  rt field.
- in_rd  in  5  rd field.
- in_imm  in  16  immediate field.
- in_target  in  ADDR_W  absolute word address for BEQ/BNE/J.
- imem_we  out  1  IMEM write strobe.
- imem_addr  out  ADDR_W  IMEM word address.
- imem_wdata  out  32  encoded instruction.
- count  out  ADDR_W+1  words written this session.
- full  out  1  count == DEPTH.
- overflow_err  out  1  sticky: in_valid seen while full.

Behaviour:
- Reset (nrst=0 at a clock edge): state IDLE. All outputs are 0: in_ready, imem_we, imem_addr, imem_wdata, count, full and overflow_err.
- States:
  - IDLE: in_ready=0. start -> RUN.
  - RUN: in_ready=!full.
  - FULL: entered when count reaches DEPTH.
  - SLOT: exists only with the optional feature enabled.
- start in any state (nrst=1): count=0, overflow_err=0, next state RUN. start has priority; an in_valid in the same cycle is dropped.
- Transfer occurs when in_valid & in_ready. On the following cycle:
  - imem_we=1, imem_addr=count(before increment), imem_wdata=encoded word.
  - count increments.
  - Latency is 1 cycle.
  - Back-to-back transfers give 1 word/cycle.
  - imem_we=0 in any cycle with no write.
- When count becomes DEPTH: full=1, state FULL, in_ready=0.
- In FULL, in_valid=1 sets overflow_err. No write occurs and the address does not wrap.
- Mnemonic map, R-type (word = {000000, rs, rt, rd, 00000, funct}):
  - 0 ADD, funct 0x20
  - 1 SUB, funct 0x22
  - 2 AND, funct 0x24
  - 3 OR, funct 0x25
  - 4 SLT, funct 0x2A
- Mnemonic map, I-type (word = {op, rs, rt, imm}):
  - 5 ADDI 0x08, 6 ADDIU 0x09, 7 ANDI 0x0C, 8 ORI 0x0D, 9 SLTI 0x0A
  - 10 LUI 0x0F (rs forced to 0)
  - 11 LW 0x23, 12 SW 0x2B
- Branches: 13 BEQ 0x04, 14 BNE 0x05.
  - Word = {op, rs, rt, off16}.
  - off = in_target - (write_addr + 1), computed as signed 17-bit and truncated to 16 bits.
- Jump: 15 J 0x02. Word = {000010, zero-extended in_target to 26 bits}.
- in_rd and in_imm are ignored where a format does not use them.
- Fields are latched at transfer; changes to inputs after the handshake have no effect.
- in_ready is a registered function of state and count only. It does not depend on in_valid.

Optional Feature:
- Macro DELAY_SLOT_NOP_EN.
- When defined: after any BEQ/BNE/J write, the FSM enters SLOT for one cycle.
  - In SLOT: in_ready=0 and a NOP (0x00000000) is written at the next address; count increments again.
  - Branch offsets are still computed from the branch's own address.
  - If the branch write makes count == DEPTH, SLOT is skipped and the FSM goes to FULL.
- When undefined: the SLOT state and its logic do not exist. Branches and jumps are written as single words like any other instruction.

Test Plan:
- Reset then start; ADD rs=1 rt=2 rd=3 -> next cycle imem_we=1, addr=0, wdata=0x00221820; count=1.
- Back-to-back ADDI rt=1 rs=0 imm=5, LW rt=2 rs=1 imm=4, SW rt=2 rs=1 imm=8 -> 0x20010005@0, 0x8C220004@1, 0xAC220008@2 on consecutive cycles.
- BEQ rs=1 rt=2 target=0 written at addr 3 -> 0x1022FFFC. J target=0x10 -> 0x08000010.
  - With DELAY_SLOT_NOP_EN: 0x00000000 at addr 4, in_ready low for one cycle.
- DEPTH=4: four writes -> full=1, in_ready=0. A fifth in_valid -> overflow_err=1 and no imem_we. Then start -> overflow_err=0, count=0, in_ready=1.
- nrst=0 mid-stream with in_valid high -> next cycle all outputs 0, state IDLE; in_valid is ignored until start.
- start and in_valid in the same cycle -> no write the next cycle, count=0.
